// File: rtl/modrm_sib_decode.sv
// ModR/M + SIB + displacement decoder between prefetch FIFO and sequencer.
// Pops operand bytes, forms the effective address, flags SS-default bases.
module modrm_sib_decode #(
  parameter bit ADDR32_EN = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         addr32,
  input  logic [255:0] regs,
  output logic         fifo_rd_en,
  input  logic [7:0]   fifo_rd_data,
  input  logic         fifo_empty,
  output logic         busy,
  output logic         complete,
  output logic [31:0]  effective_address,
  output logic [2:0]   regnum,
  output logic         rm_is_reg,
  output logic [2:0]   rm_regnum,
  output logic         default_ss
);

  typedef enum logic [2:0] {
    S_IDLE, S_MODRM, S_SIB, S_DISP, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  req_q, req_d;
  logic [2:0]  rcv_q, rcv_d;
  logic        pend_q, pend_d;
  logic        a32_q, a32_d;
  logic [7:0]  modrm_q, modrm_d;
  logic [7:0]  sib_q, sib_d;
  logic [31:0] disp_q, disp_d;
  logic [31:0] ea_q, ea_d;
  logic [2:0]  regnum_q, regnum_d;
  logic [2:0]  rmreg_q, rmreg_d;
  logic        isreg_q, isreg_d;
  logic        ss_q, ss_d;

  logic [7:0]  modrm_c, sib_c;
  logic [31:0] disp_c, disp_ext;
  logic [1:0]  mod_c, didx;
  logic [2:0]  rm_c, dlen_c, len_c, need_c;
  logic        modrm_known, sib_known, has_sib, last_c;
  logic [15:0] base16;
  logic [31:0] base32, idx32, ea_c;
  logic [2:0]  base_idx;
  logic        no_base, ss_c;

  function automatic logic [31:0] gpr(input logic [2:0] i);
    return regs[32*i +: 32];
  endfunction

  function automatic logic [15:0] gpr16(input logic [2:0] i);
    return regs[32*i +: 16];
  endfunction

  // Operand decode: merges the byte arriving this cycle with stored bytes
  always_comb begin
    modrm_c = (pend_q && rcv_q == 3'd0) ? fifo_rd_data : modrm_q;
    modrm_known = (rcv_q != 3'd0) || pend_q;
    mod_c = modrm_c[7:6];
    rm_c = modrm_c[2:0];
    has_sib = a32_q && mod_c != 2'd3 && rm_c == 3'd4;
    sib_known = (rcv_q >= 3'd2) || (pend_q && rcv_q == 3'd1);
    sib_c = (pend_q && rcv_q == 3'd1 && has_sib) ? fifo_rd_data : sib_q;
    base_idx = has_sib ? sib_c[2:0] : rm_c;
    no_base = a32_q && mod_c == 2'd0 && base_idx == 3'd5;
    dlen_c = 3'd0;
    unique case (1'b1)
      mod_c == 2'd3: dlen_c = 3'd0;
      mod_c == 2'd1: dlen_c = 3'd1;
      mod_c == 2'd2: dlen_c = a32_q ? 3'd4 : 3'd2;
      default: begin
        if (a32_q) dlen_c = no_base ? 3'd4 : 3'd0;
        else dlen_c = (rm_c == 3'd6) ? 3'd2 : 3'd0;
      end
    endcase
    len_c = 3'd1 + {2'b0, has_sib} + dlen_c;
    if (!modrm_known) need_c = 3'd1;
    else if (has_sib && mod_c == 2'd0 && !sib_known) need_c = 3'd2;
    else need_c = len_c;
    didx = 2'(rcv_q - 3'd1 - {2'b0, has_sib});
    disp_c = disp_q;
    if (pend_q && rcv_q >= (3'd1 + {2'b0, has_sib}))
      disp_c[{didx, 3'b000} +: 8] = fifo_rd_data;
    last_c = pend_q && (rcv_q + 3'd1 == len_c);
  end

  // Effective address and SS-default flag from the merged operand bytes
  always_comb begin
    disp_ext = '0;
    case (dlen_c)
      3'd1: disp_ext = {{24{disp_c[7]}}, disp_c[7:0]};
      3'd2: disp_ext = {16'h0, disp_c[15:0]};
      3'd4: disp_ext = disp_c;
      default: disp_ext = '0;
    endcase
    case (rm_c)
      3'd0: base16 = gpr16(3'd3) + gpr16(3'd6);
      3'd1: base16 = gpr16(3'd3) + gpr16(3'd7);
      3'd2: base16 = gpr16(3'd5) + gpr16(3'd6);
      3'd3: base16 = gpr16(3'd5) + gpr16(3'd7);
      3'd4: base16 = gpr16(3'd6);
      3'd5: base16 = gpr16(3'd7);
      3'd6: base16 = (mod_c == 2'd0) ? 16'h0 : gpr16(3'd5);
      default: base16 = gpr16(3'd3);
    endcase
    base32 = no_base ? 32'h0 : gpr(base_idx);
    idx32 = (has_sib && sib_c[5:3] != 3'd4) ?
            (gpr(sib_c[5:3]) << sib_c[7:6]) : 32'h0;
    ea_c = '0;
    ss_c = 1'b0;
    if (mod_c == 2'd3) begin
      ea_c = '0;
      ss_c = 1'b0;
    end else if (a32_q) begin
      ea_c = base32 + idx32 + disp_ext;
      ss_c = !no_base && (base_idx == 3'd4 || base_idx == 3'd5);
    end else begin
      ea_c = {16'h0, base16 + disp_ext[15:0]};
      ss_c = rm_c == 3'd2 || rm_c == 3'd3 ||
             (rm_c == 3'd6 && mod_c != 2'd0);
    end
  end

  // Sequencer: pop requests, byte capture and result latching
  always_comb begin
    state_d = state_q;
    req_d = req_q;
    rcv_d = rcv_q;
    pend_d = 1'b0;
    a32_d = a32_q;
    modrm_d = modrm_q;
    sib_d = sib_q;
    disp_d = disp_q;
    ea_d = ea_q;
    regnum_d = regnum_q;
    rmreg_d = rmreg_q;
    isreg_d = isreg_q;
    ss_d = ss_q;
    fifo_rd_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          fifo_rd_en = ~fifo_empty;
          a32_d = ADDR32_EN & addr32;
          modrm_d = '0;
          sib_d = '0;
          disp_d = '0;
          rcv_d = '0;
          req_d = {2'b0, fifo_rd_en};
          pend_d = fifo_rd_en;
          state_d = S_MODRM;
        end
      end
      S_MODRM, S_SIB, S_DISP: begin
        fifo_rd_en = ~fifo_empty && (req_q < need_c);
        req_d = req_q + {2'b0, fifo_rd_en};
        pend_d = fifo_rd_en;
        if (pend_q) begin
          rcv_d = rcv_q + 3'd1;
          modrm_d = modrm_c;
          sib_d = sib_c;
          disp_d = disp_c;
          if (last_c) begin
            ea_d = ea_c;
            regnum_d = modrm_c[5:3];
            rmreg_d = modrm_c[2:0];
            isreg_d = mod_c == 2'd3;
            ss_d = ss_c;
            state_d = S_DONE;
          end else if (state_q == S_MODRM && has_sib) begin
            state_d = S_SIB;
          end else begin
            state_d = S_DISP;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      req_q <= '0;
      rcv_q <= '0;
      pend_q <= 1'b0;
      a32_q <= 1'b0;
      modrm_q <= '0;
      sib_q <= '0;
      disp_q <= '0;
      ea_q <= '0;
      regnum_q <= '0;
      rmreg_q <= '0;
      isreg_q <= 1'b0;
      ss_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q <= req_d;
      rcv_q <= rcv_d;
      pend_q <= pend_d;
      a32_q <= a32_d;
      modrm_q <= modrm_d;
      sib_q <= sib_d;
      disp_q <= disp_d;
      ea_q <= ea_d;
      regnum_q <= regnum_d;
      rmreg_q <= rmreg_d;
      isreg_q <= isreg_d;
      ss_q <= ss_d;
    end
  end

  assign busy = state_q != S_IDLE;
  assign complete = state_q == S_DONE;
  assign effective_address = ea_q;
  assign regnum = regnum_q;
  assign rm_is_reg = isreg_q;
  assign rm_regnum = rmreg_q;
  assign default_ss = ss_q;

endmodule

// File: tb/tb_modrm_sib_decode.sv
// Bench for modrm_sib_decode: directed cases plus random operands,
// FIFO stalls and ignored starts, checked against a byte-level model.
module tb_modrm_sib_decode;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         addr32 = 1'b0;
  logic [255:0] regs = '0;
  logic         fifo_rd_en;
  logic [7:0]   fifo_rd_data = '0;
  logic         fifo_empty = 1'b1;
  logic         busy, complete, rm_is_reg, default_ss;
  logic [31:0]  effective_address;
  logic [2:0]   regnum, rm_regnum;

  modrm_sib_decode dut (
    .clk(clk), .reset(reset), .start(start), .addr32(addr32),
    .regs(regs), .fifo_rd_en(fifo_rd_en),
    .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
    .busy(busy), .complete(complete),
    .effective_address(effective_address), .regnum(regnum),
    .rm_is_reg(rm_is_reg), .rm_regnum(rm_regnum),
    .default_ss(default_ss)
  );

  always #5 clk = ~clk;

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;
  logic [7:0]  q[$];
  logic [7:0]  stim[$];
  logic [31:0] r[8];
  bit          stall_en = 1'b0;
  int          pops = 0;
  logic [31:0] exp_ea;
  int          exp_len, exp_reg, exp_rm, exp_isreg, exp_ss;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, want);
  endtask

  // FIFO model: data lands the cycle after a pop request
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      if (fifo_empty) chk("rd_on_empty", 1, 0);
      if (q.size() > 0) fifo_rd_data <= q.pop_front();
      pops++;
    end
  end

  always @(negedge clk)
    fifo_empty = (q.size() == 0) ||
                 (stall_en && $urandom_range(0, 2) == 0);

  task automatic load_regs();
    for (int i = 0; i < 8; i++) regs[32*i +: 32] = r[i];
  endtask

  function automatic int disp_len(input bit a32, input int m,
                                  input int sb);
    int md, rm, base;
    md = m / 64;
    rm = m % 8;
    if (md == 3) return 0;
    if (md == 1) return 1;
    if (!a32) return (md == 2 || rm == 6) ? 2 : 0;
    if (md == 2) return 4;
    base = (rm == 4) ? sb % 8 : rm;
    return (base == 5) ? 4 : 0;
  endfunction

  task automatic model_calc(input bit a32);
    int m, md, rm, sb, p, dl, base, idx, sc;
    logic [31:0] d, ea;
    int first[8] = '{3, 3, 5, 5, 6, 7, 5, 3};
    int second[8] = '{6, 7, 6, 7, -1, -1, -1, -1};
    bit nobase;
    m = stim[0];
    md = m / 64;
    rm = m % 8;
    p = (a32 && md != 3 && rm == 4) ? 2 : 1;
    sb = (p == 2) ? int'(stim[1]) : 0;
    dl = disp_len(a32, m, sb);
    d = 0;
    for (int i = 0; i < dl; i++) d = d + (32'(stim[p+i]) << (8 * i));
    if (dl == 1 && d >= 128) d = d + 32'hFFFFFF00;
    exp_len = p + dl;
    exp_reg = (m / 8) % 8;
    exp_rm = rm;
    exp_isreg = (md == 3);
    ea = 0;
    exp_ss = 0;
    if (md != 3 && !a32) begin
      if (!(md == 0 && rm == 6)) begin
        ea = r[first[rm]] & 32'hFFFF;
        if (second[rm] >= 0) ea = ea + (r[second[rm]] & 32'hFFFF);
      end
      ea = (ea + d) & 32'hFFFF;
      exp_ss = (rm == 2 || rm == 3 || (rm == 6 && md != 0));
    end else if (md != 3) begin
      base = (p == 2) ? sb % 8 : rm;
      idx = (sb / 8) % 8;
      sc = sb / 64;
      nobase = (md == 0 && base == 5);
      ea = d;
      if (!nobase) ea = ea + r[base];
      if (p == 2 && idx != 4) ea = ea + r[idx] * (32'd1 << sc);
      exp_ss = !nobase && (base == 4 || base == 5);
    end
    exp_ea = ea;
  endtask

  task automatic do_decode(input string tag, input bit a32,
                           input bit stall, input bit poke,
                           input int want_lat);
    int cyc;
    bit seen;
    load_regs();
    model_calc(a32);
    q = stim;
    pops = 0;
    stall_en = stall;
    @(negedge clk);
    addr32 = a32;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    seen = 0;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      start = poke && cyc == 2 && busy && !complete;
      if (complete) seen = 1;
    end
    start = 1'b0;
    chk({tag, "_done"}, 32'(seen), 1);
    chk({tag, "_ea"}, effective_address, exp_ea);
    chk({tag, "_ss"}, 32'(default_ss), 32'(exp_ss));
    chk({tag, "_reg"}, 32'(regnum), 32'(exp_reg));
    chk({tag, "_rm"}, 32'(rm_regnum), 32'(exp_rm));
    chk({tag, "_isreg"}, 32'(rm_is_reg), 32'(exp_isreg));
    chk({tag, "_pops"}, 32'(pops), 32'(exp_len));
    if (!stall) chk({tag, "_lat"}, 32'(cyc), 32'(exp_len + 1));
    if (want_lat > 0) chk({tag, "_cyc"}, 32'(cyc), 32'(want_lat));
    stall_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(complete), 0);
    chk({tag, "_hold"}, effective_address, exp_ea);
    chk({tag, "_idle"}, 32'(busy), 0);
    chk({tag, "_extra"}, 32'(pops), 32'(exp_len));
  endtask

  initial begin
    for (int i = 0; i < 8; i++) r[i] = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cpl", 32'(complete), 0);
    chk("rst_ea", effective_address, 0);
    chk("rst_flags", {rm_is_reg, default_ss, regnum, rm_regnum}, 0);
    chk("rst_rden", 32'(fifo_rd_en), 0);

    r[5] = 32'h1000;
    stim = '{8'h46, 8'hFE};
    do_decode("d16bp", 1'b0, 1'b0, 1'b0, 3);
    chk("d16bp_abs", effective_address, 32'h0FFE);

    stim = '{8'h06, 8'h34, 8'h12};
    do_decode("d16abs", 1'b0, 1'b0, 1'b0, 0);
    chk("d16abs_abs", effective_address, 32'h1234);

    r[3] = 32'hFFFF;
    r[6] = 32'h2;
    stim = '{8'h00};
    do_decode("d16wrap", 1'b0, 1'b0, 1'b0, 2);
    chk("d16wrap_abs", effective_address, 32'h0001);

    r[0] = 32'h100;
    r[1] = 32'h4;
    stim = '{8'h44, 8'h88, 8'h10};
    do_decode("d32sib", 1'b1, 1'b0, 1'b0, 4);
    chk("d32sib_abs", effective_address, 32'h120);

    stim = '{8'h04, 8'h25, 8'h78, 8'h56, 8'h34, 8'h12};
    do_decode("d32abs", 1'b1, 1'b0, 1'b0, 7);
    chk("d32abs_abs", effective_address, 32'h12345678);

    stim = '{8'hC3};
    do_decode("mod11", 1'b1, 1'b0, 1'b1, 2);
    chk("mod11_abs", {rm_is_reg, rm_regnum}, 4'hB);

    stim = '{8'h84, 8'h25, 8'h01, 8'h02, 8'h03, 8'h04};
    do_decode("stall", 1'b1, 1'b1, 1'b0, 0);

    // reset while the SIB byte is arriving aborts the decode
    begin
      int ncpl;
      q = '{8'h04, 8'h25, 8'h01, 8'h02, 8'h03, 8'h04};
      @(negedge clk);
      addr32 = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rst_mid_busy", 32'(busy), 0);
      chk("rst_mid_ea", effective_address, 0);
      ncpl = 0;
      repeat (8) begin
        @(negedge clk);
        if (complete) ncpl++;
      end
      chk("rst_mid_cpl", 32'(ncpl), 0);
      q.delete();
    end

    for (int t = 0; t < 150; t++) begin
      bit a32;
      int m, sb, dl;
      a32 = 1'($urandom);
      for (int i = 0; i < 8; i++) r[i] = $urandom;
      m = $urandom_range(0, 255);
      stim = '{8'(m)};
      sb = 0;
      if (a32 && m / 64 != 3 && m % 8 == 4) begin
        sb = $urandom_range(0, 255);
        stim.push_back(8'(sb));
      end
      dl = disp_len(a32, m, sb);
      for (int i = 0; i < dl; i++) stim.push_back(8'($urandom));
      do_decode("rnd", a32, 1'($urandom), $urandom_range(0, 3) == 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
